// File: rtl/branch_predict_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl_pkg
// Description : Shared constants for the branch predictor: FSM state
//               encoding, counter reset value and saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_predict_ctrl_pkg;

    // Two-state recovery FSM.
    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } bp_state_e;

    // Two-bit predictor counter limits and the default weakly-not-taken start.
    localparam logic [1:0]  CNT_INIT_DEFAULT = 2'b01;
    localparam logic [1:0]  CNT_MAX          = 2'b11;
    localparam logic [1:0]  CNT_MIN          = 2'b00;

    // Statistics counters stick at all-ones instead of wrapping.
    localparam logic [31:0] STATS_MAX        = 32'hFFFF_FFFF;

    // Saturating increment of a statistics counter.
    function automatic logic [31:0] stats_inc(input logic [31:0] value);
        return (value == STATS_MAX) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_ctrl_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : One predictor table entry: a 2-bit up/down counter that
//               saturates at 3 and 0, updated only when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import branch_predict_ctrl_pkg::*;
#(
    parameter logic [1:0] INIT = CNT_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,      // asynchronous, active-low
    input  logic       en,
    input  logic       inc,      // 1 = count up, 0 = count down
    output logic [1:0] cnt
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next value: move one step toward the outcome, clamped at the limits.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (inc) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 2'd1;
                end
            end else begin
                if (cnt_q != CNT_MIN) begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
        end
    end

    // Counter register, forced to its start value while reset is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl
// Description : Bimodal branch predictor with 2-bit saturating counters,
//               registered mispredict pulse / redirect address, and
//               saturating resolved-branch and mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] CNT_INIT = CNT_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,              // asynchronous assert, active-low
    input  logic [31:0] id_pc,
    input  logic        id_is_branch,
    output logic        predict_taken,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_pred,
    output logic        wrong_prediction,
    output logic [31:0] recover_pc,
    input  logic        stats_clr,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);

    localparam int TBL_SIZE = 1 << IDX_BITS;

    // Word-aligned PCs: drop the two byte-offset bits before indexing.
    logic [IDX_BITS-1:0] w_id_idx;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [1:0]          w_table [TBL_SIZE];
    logic                w_accept;
    logic                w_mispredict;
    logic                w_pc_unused;

    bp_state_e   state_q,            state_d;
    logic        wrong_prediction_q, wrong_prediction_d;
    logic [31:0] recover_pc_q,       recover_pc_d;
    logic [31:0] br_count_q,         br_count_d;
    logic [31:0] miss_count_q,       miss_count_d;

    assign w_id_idx = id_pc[IDX_BITS+1:2];
    assign w_ex_idx = ex_pc[IDX_BITS+1:2];

    // PC bits outside the index field carry no information for the table.
    assign w_pc_unused = ^{id_pc[31:IDX_BITS+2], id_pc[1:0], ex_pc[1:0]};

    // A resolved branch counts only in NORMAL; in RECOVER it is wrong-path.
    assign w_accept     = ex_br_valid && (state_q == ST_NORMAL);
    assign w_mispredict = w_accept && (ex_taken != ex_pred);

    // Counter table: one saturating counter per index, updated on accept.
    for (genvar gi = 0; gi < TBL_SIZE; gi++) begin : g_table
        sat_counter2 #(
            .INIT (CNT_INIT)
        ) u_entry (
            .clk (clk),
            .rst (rst),
            .en  (w_accept && (w_ex_idx == IDX_BITS'(gi))),
            .inc (ex_taken),
            .cnt (w_table[gi])
        );
    end

    // Zero-latency lookup; reads the stored value, so a same-cycle update
    // to the same entry is not visible until the next cycle.
    assign predict_taken = id_is_branch && w_table[w_id_idx][1];

    // Next-state and output logic for the recovery FSM and statistics.
    always_comb begin
        state_d            = state_q;
        wrong_prediction_d = 1'b0;
        recover_pc_d       = recover_pc_q;
        br_count_d         = br_count_q;
        miss_count_d       = miss_count_q;

        case (state_q)
            ST_NORMAL: begin
                if (w_mispredict) begin
                    state_d            = ST_RECOVER;
                    wrong_prediction_d = 1'b1;
                    recover_pc_d       = ex_taken ? ex_target : (ex_pc + 32'd4);
                end
            end
            ST_RECOVER: begin
                state_d = ST_NORMAL;
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase

        // Clear wins over any increment arriving in the same cycle.
        if (stats_clr) begin
            br_count_d   = '0;
            miss_count_d = '0;
        end else begin
            if (w_accept) begin
                br_count_d = stats_inc(br_count_q);
            end
            if (w_mispredict) begin
                miss_count_d = stats_inc(miss_count_q);
            end
        end
    end

    // State, pulse, redirect and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= ST_NORMAL;
            wrong_prediction_q <= 1'b0;
            recover_pc_q       <= '0;
            br_count_q         <= '0;
            miss_count_q       <= '0;
        end else begin
            state_q            <= state_d;
            wrong_prediction_q <= wrong_prediction_d;
            recover_pc_q       <= recover_pc_d;
            br_count_q         <= br_count_d;
            miss_count_q       <= miss_count_d;
        end
    end

    assign wrong_prediction = wrong_prediction_q;
    assign recover_pc       = recover_pc_q;
    assign br_count         = br_count_q;
    assign miss_count       = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_ctrl
// Description : Self-checking bench for branch_predict_ctrl: directed vector
//               table, hand-written corner sequences and a random phase
//               checked against a behavioural predictor model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

    localparam int N_ENT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_pc;
    logic        id_is_branch;
    logic        predict_taken;
    logic        ex_br_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_pred;
    logic        wrong_prediction;
    logic [31:0] recover_pc;
    logic        stats_clr;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    branch_predict_ctrl #(
        .IDX_BITS (4),
        .CNT_INIT (2'b01)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_pc            (id_pc),
        .id_is_branch     (id_is_branch),
        .predict_taken    (predict_taken),
        .ex_br_valid      (ex_br_valid),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_taken         (ex_taken),
        .ex_pred          (ex_pred),
        .wrong_prediction (wrong_prediction),
        .recover_pc       (recover_pc),
        .stats_clr        (stats_clr),
        .br_count         (br_count),
        .miss_count       (miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: counters as plain integers 0..3.
    int          m_cnt [N_ENT];
    bit          m_in_recover;
    bit          m_wp;
    logic [31:0] m_rpc;
    logic [31:0] m_br;
    logic [31:0] m_miss;

    typedef struct {
        logic [31:0] id_pc;
        logic        id_br;
        logic        v;
        logic [31:0] epc;
        logic [31:0] tgt;
        logic        tk;
        logic        pr;
        logic        clr;
        logic        wp;
        logic [31:0] rpc;
        logic [31:0] br;
        logic [31:0] miss;
        logic        pt;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % N_ENT);
    endfunction

    function automatic logic mpred(input logic idb, input logic [31:0] pc);
        return idb && (m_cnt[midx(pc)] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_ENT; i++) m_cnt[i] = 1;
        m_in_recover = 0;
        m_wp         = 0;
        m_rpc        = '0;
        m_br         = '0;
        m_miss       = '0;
    endtask

    // Advance the model by one clock using the inputs now applied.
    task automatic model_edge();
        bit acc;
        bit miss;
        int k;
        acc  = ex_br_valid && !m_in_recover;
        miss = acc && (ex_taken != ex_pred);
        if (acc) begin
            k = midx(ex_pc);
            if (ex_taken) m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
            else          m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
        end
        if (miss) m_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
        if (stats_clr) begin
            m_br   = '0;
            m_miss = '0;
        end else begin
            if (acc  && m_br   != 32'hFFFF_FFFF) m_br++;
            if (miss && m_miss != 32'hFFFF_FFFF) m_miss++;
        end
        m_in_recover = miss;
        m_wp         = miss;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ex_br_valid = 0;
        stats_clr   = 0;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [31:0] tgt,
                                input logic tk, input logic pr);
        ex_br_valid = 1;
        ex_pc       = pc;
        ex_target   = tgt;
        ex_taken    = tk;
        ex_pred     = pr;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".wrong_prediction"}, 32'(wrong_prediction), 32'(m_wp));
        check({tag, ".recover_pc"},       recover_pc,            m_rpc);
        check({tag, ".br_count"},         br_count,              m_br);
        check({tag, ".miss_count"},       miss_count,            m_miss);
        check({tag, ".predict_taken"},    32'(predict_taken),    32'(mpred(id_is_branch, id_pc)));
    endtask

    function automatic vec_t mk(input logic [31:0] ipc, input logic idb, input logic v,
                                input logic [31:0] epc, input logic [31:0] tgt,
                                input logic tk, input logic pr, input logic clr,
                                input logic wp, input logic [31:0] rpc,
                                input logic [31:0] br, input logic [31:0] miss,
                                input logic pt);
        vec_t r;
        r.id_pc = ipc; r.id_br = idb; r.v = v; r.epc = epc; r.tgt = tgt;
        r.tk = tk; r.pr = pr; r.clr = clr; r.wp = wp; r.rpc = rpc;
        r.br = br; r.miss = miss; r.pt = pt;
        return r;
    endfunction

    // Watchdog: the run is a few thousand cycles; anything longer is a hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Per-cycle vectors from reset; expectations sampled after the edge.
        //            id_pc  idb v  ex_pc         target       tk pr clr   wp rpc          br miss pt
        vecs[0]  = mk(32'h40, 1, 0, 32'h40,       32'h200,      0, 0, 0,   0, 32'h0,       0, 0, 0);
        vecs[1]  = mk(32'h40, 1, 1, 32'h40,       32'h200,      1, 0, 0,   1, 32'h200,     1, 1, 1);
        vecs[2]  = mk(32'h40, 1, 0, 32'h40,       32'h200,      1, 0, 0,   0, 32'h200,     1, 1, 1);
        vecs[3]  = mk(32'h40, 1, 0, 32'h40,       32'h200,      1, 0, 0,   0, 32'h200,     1, 1, 1);
        vecs[4]  = mk(32'h40, 1, 1, 32'h40,       32'h200,      1, 0, 0,   1, 32'h200,     2, 2, 1);
        vecs[5]  = mk(32'h40, 1, 0, 32'h40,       32'h200,      1, 0, 0,   0, 32'h200,     2, 2, 1);
        vecs[6]  = mk(32'h40, 1, 0, 32'h40,       32'h200,      1, 0, 0,   0, 32'h200,     2, 2, 1);
        vecs[7]  = mk(32'h40, 1, 1, 32'h40,       32'h200,      1, 0, 0,   1, 32'h200,     3, 3, 1);
        vecs[8]  = mk(32'h40, 1, 0, 32'h40,       32'h200,      1, 0, 0,   0, 32'h200,     3, 3, 1);
        vecs[9]  = mk(32'h40, 1, 1, 32'h100,      32'h300,      0, 1, 0,   1, 32'h104,     4, 4, 1);
        vecs[10] = mk(32'h40, 1, 1, 32'h100,      32'h300,      0, 1, 0,   0, 32'h104,     4, 4, 1);
        vecs[11] = mk(32'h40, 1, 0, 32'h100,      32'h300,      0, 1, 0,   0, 32'h104,     4, 4, 1);
        vecs[12] = mk(32'h40, 1, 1, 32'h40,       32'h200,      1, 1, 0,   0, 32'h104,     5, 4, 1);
        vecs[13] = mk(32'h40, 1, 1, 32'h40,       32'h200,      0, 0, 1,   0, 32'h104,     0, 0, 1);
        vecs[14] = mk(32'h40, 0, 0, 32'h40,       32'h200,      0, 0, 0,   0, 32'h104,     0, 0, 0);
        vecs[15] = mk(32'h40, 1, 1, 32'h40,       32'h200,      0, 0, 0,   0, 32'h104,     1, 0, 0);
        vecs[16] = mk(32'h40, 1, 1, 32'h40,       32'h200,      0, 0, 0,   0, 32'h104,     2, 0, 0);
        vecs[17] = mk(32'h40, 1, 1, 32'h40,       32'h200,      0, 0, 0,   0, 32'h104,     3, 0, 0);
        vecs[18] = mk(32'h40, 1, 1, 32'h40,       32'h1000,     1, 0, 0,   1, 32'h1000,    4, 1, 0);
        vecs[19] = mk(32'h40, 1, 0, 32'h40,       32'h1000,     1, 0, 0,   0, 32'h1000,    4, 1, 0);
        vecs[20] = mk(32'h40, 1, 1, 32'h40,       32'h1000,     1, 1, 0,   0, 32'h1000,    5, 1, 1);
        vecs[21] = mk(32'h40, 1, 1, 32'hFFFFFFFC, 32'h8,        0, 1, 0,   1, 32'h0,       6, 2, 1);
        vecs[22] = mk(32'h40, 1, 0, 32'hFFFFFFFC, 32'h8,        0, 1, 0,   0, 32'h0,       6, 2, 1);

        rst = 0;
        id_pc = 32'h40; id_is_branch = 1;
        ex_pc = 0; ex_target = 0; ex_taken = 0; ex_pred = 0;
        set_idle();
        #1;
        check("in_reset.predict_taken", 32'(predict_taken), 32'h0);

        // Reset values with a branch at 0x40 in ID.
        do_reset();
        #1;
        check("reset.predict_taken",    32'(predict_taken),    32'h0);
        check("reset.wrong_prediction", 32'(wrong_prediction), 32'h0);
        check("reset.recover_pc",       recover_pc,            32'h0);
        check("reset.br_count",         br_count,              32'h0);
        check("reset.miss_count",       miss_count,            32'h0);

        // Directed vector table.
        for (int i = 0; i < 23; i++) begin
            id_pc        = vecs[i].id_pc;
            id_is_branch = vecs[i].id_br;
            ex_br_valid  = vecs[i].v;
            ex_pc        = vecs[i].epc;
            ex_target    = vecs[i].tgt;
            ex_taken     = vecs[i].tk;
            ex_pred      = vecs[i].pr;
            stats_clr    = vecs[i].clr;
            tick();
            check($sformatf("vec%0d.wrong_prediction", i), 32'(wrong_prediction), 32'(vecs[i].wp));
            check($sformatf("vec%0d.recover_pc", i),       recover_pc,            vecs[i].rpc);
            check($sformatf("vec%0d.br_count", i),         br_count,              vecs[i].br);
            check($sformatf("vec%0d.miss_count", i),       miss_count,            vecs[i].miss);
            check($sformatf("vec%0d.predict_taken", i),    32'(predict_taken),    32'(vecs[i].pt));
        end
        set_idle();

        // Same-cycle lookup and update of index 5: no bypass.
        do_reset();
        id_pc = 32'h14; id_is_branch = 1;
        drive_update(32'h14, 32'h500, 1, 0);
        #1;
        check("bypass.same_cycle_pt", 32'(predict_taken), 32'h0);
        tick();
        set_idle();
        #1;
        check("bypass.next_cycle_pt", 32'(predict_taken), 32'h1);

        // Reset asserted in the middle of the RECOVER cycle.
        do_reset();
        id_pc = 32'h40; id_is_branch = 1;
        drive_update(32'h40, 32'h200, 1, 0);
        tick();
        set_idle();
        check("midrec.pulse_before_rst", 32'(wrong_prediction), 32'h1);
        check("midrec.pt_before_rst",    32'(predict_taken),    32'h1);
        rst = 0;
        model_reset();
        #1;
        check("midrec.pulse_aborted",  32'(wrong_prediction), 32'h0);
        check("midrec.recover_pc",     recover_pc,            32'h0);
        check("midrec.counter_reinit", 32'(predict_taken),    32'h0);
        check("midrec.br_count",       br_count,              32'h0);
        @(negedge clk);
        rst = 1;
        drive_update(32'h80, 32'h900, 1, 0);
        tick();
        set_idle();
        check_model("midrec.resume");

        // Statistics saturation and clear priority.
        do_reset();
        tick();
        force dut.br_count_q   = 32'hFFFF_FFFE;
        force dut.miss_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.br_count_q;
        release dut.miss_count_q;
        #1;
        check("sat.preload_br", br_count, 32'hFFFF_FFFE);
        drive_update(32'h40, 32'h200, 1, 1);
        tick();
        check("sat.br_upd1", br_count, 32'hFFFF_FFFF);
        tick();
        check("sat.br_upd2", br_count, 32'hFFFF_FFFF);
        drive_update(32'h40, 32'h200, 1, 0);
        tick();
        check("sat.br_upd3",   br_count,   32'hFFFF_FFFF);
        check("sat.miss_upd1", miss_count, 32'hFFFF_FFFF);
        set_idle();
        tick();
        drive_update(32'h40, 32'h200, 0, 1);
        tick();
        check("sat.miss_upd2", miss_count, 32'hFFFF_FFFF);
        check("sat.miss_pulse", 32'(wrong_prediction), 32'h1);
        set_idle();
        tick();
        drive_update(32'h40, 32'h200, 0, 1);
        stats_clr = 1;
        tick();
        check("clr.br_count",   br_count,   32'h0);
        check("clr.miss_count", miss_count, 32'h0);
        set_idle();

        // Random traffic against the behavioural model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            id_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            id_is_branch = 1'($urandom_range(0, 3) != 0);
            ex_br_valid  = 1'($urandom_range(0, 1));
            ex_pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                        : ($urandom & 32'h0000_00FC);
            ex_target    = $urandom;
            ex_taken     = 1'($urandom_range(0, 1));
            ex_pred      = 1'($urandom_range(0, 1));
            stats_clr    = 1'($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) == 0) id_pc = ex_pc;
            #1;
            check("rand.pre_edge_pt", 32'(predict_taken), 32'(mpred(id_is_branch, id_pc)));
            tick();
            check_model("rand");
        end
        set_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
